osd_text_ctrl: RTL
==================

// Module: osd_text_ctrl
// PURPOSE
//   Command sequencer for the OSD 40x30 character buffer. Owns the write/read port of the
//   dual-port text RAM whose other port feeds the glyph pipeline. Host issues put-char,
//   set-cursor, clear-screen and scroll-up commands through a valid/ready handshake.
//   Block tracks the cursor and runs multi-cycle clear and scroll sequences.
// PARAMETERS
//   COLS      40     characters per row
//   ROWS      30     rows per screen
//   ADDR_W    11     RAM address width; COLS*ROWS <= 2**ADDR_W
//   CLR_CHAR  8'h20  fill code used by CLEAR and the scroll fill of the last row
// PORTS
//   clk        in   1       system clock; all logic on rising edge
//   reset      in   1       synchronous, active-high reset
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//   cmd_op     in   2       00 PUTC, 01 SETXY, 10 CLEAR, 11 SCROLL
//   cmd_data   in   16      PUTC: [7:0] char; SETXY: [5:0] col, [12:8] row; else ignored
//   ram_addr   out  ADDR_W  text RAM address = row*COLS + col
//   ram_we     out  1       text RAM write strobe
//   ram_wdata  out  8       text RAM write data
//   ram_rdata  in   8       text RAM read data, valid 1 cycle after ram_addr presented
//   cur_col    out  6       cursor column, 0..COLS-1
//   cur_row    out  5       cursor row, 0..ROWS-1
//   busy       out  1       CLEAR or SCROLL sequence in progress
// BEHAVIOUR
// - Reset: state IDLE, cur_col=0, cur_row=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, cmd_ready=1.
// - Reset mid-sequence: IDLE next cycle; RAM left partly written, no repair.
// - States: IDLE, PUT, CLEAR, SCR_RD, SCR_WR, SCR_FILL. cmd_ready=1 only in IDLE; busy=1 in
//   CLEAR/SCR_*. ram_* decoded from state regs; ram_we=0 in IDLE and SCR_RD.
// - Commands are accepted only in IDLE; cmd_valid while not ready is held by the host, never dropped.
// - PUTC char c, ordinary: IDLE->PUT. PUT cycle: ram_we=1, addr=cur_row*COLS+cur_col, wdata=c.
//   Cursor then advances: col+1; at col=COLS-1: col=0, row+1.
// - PUTC 8'h0D: col=0, no write. PUTC 8'h0A: col=0, row+1, no write. Both stay in IDLE, 1 cycle.
// - Row advance from row ROWS-1: row stays ROWS-1, col=0, auto SCROLL starts next cycle (cmd_ready=0).
// - SETXY: col=min(cmd col, COLS-1), row=min(cmd row, ROWS-1); no RAM access; stays IDLE.
// - CLEAR: addr 0..COLS*ROWS-1, one write per cycle, wdata=CLR_CHAR.
//   Cursor -> (0,0) on exit, then IDLE. Duration COLS*ROWS cycles (1200).
// - SCROLL: for a=0..(ROWS-1)*COLS-1:
//   - SCR_RD: addr=a+COLS, we=0.
//   - SCR_WR: addr=a, we=1, wdata=ram_rdata.
//   Then SCR_FILL: addr=(ROWS-1)*COLS..COLS*ROWS-1, wdata=CLR_CHAR, 1 per cycle, then IDLE.
//   Duration 2*(ROWS-1)*COLS+COLS cycles (2360). Explicit SCROLL leaves cursor unchanged.
// - Address counter sized ADDR_W; terminal compare on exact last address, no wrap past COLS*ROWS-1.
// - Video read port is independent; tearing during CLEAR/SCROLL is accepted.
// TESTING
// - Reset, then PUTC 0x41 -> one cycle we=1 addr=0 wdata=0x41; cursor (1,0); cmd_ready back to 1.
// - SETXY col=50,row=40 -> cursor (39,29), no we. PUTC 0x5A -> write addr 1199; busy for 2360
//   cycles; RAM row k = old row k+1; row 29 all 0x20; cursor (0,29).
// - CLEAR from cursor (12,7) -> exactly 1200 writes of 0x20 at addr 0..1199 in order; cursor (0,0).
// - Cursor (39,5), PUTC 0x42 -> write addr 239; cursor (0,6). PUTC 0x0A at (3,6) -> (0,7), no write.
// - Preloaded RAM, SCROLL at cursor (4,4) -> addr 0 receives old addr 40 data; cursor stays (4,4).
// - Reset asserted 100 cycles into CLEAR -> next cycle busy=0, cmd_ready=1, we=0, cursor (0,0).

Source files
------------

// File: rtl/osd_text_ctrl_if.sv
// Host command channel plus the controller's port of the dual-port text RAM.
// The master side is the host and RAM; the slave side is the controller.
interface osd_text_ctrl_if #(
  parameter int ADDR_W = 11
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [15:0]       cmd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_data, ram_rdata,
    input  cmd_ready, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, ram_rdata,
    output cmd_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/osd_text_ctrl.sv
// OSD text-buffer command sequencer: cursor tracking, put-char, clear and scroll-up sequences.
// Commands are accepted in IDLE only; clear takes COLS*ROWS cycles, scroll 2*(ROWS-1)*COLS+COLS.
module osd_text_ctrl #(
  parameter int          COLS     = 40,
  parameter int          ROWS     = 30,
  parameter int          ADDR_W   = 11,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  osd_text_ctrl_if.slave bus,
  output logic [5:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PUT, CLEAR, SCR_RD, SCR_WR, SCR_FILL} state_t;

  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] MV_LAST_A = ADDR_W'((ROWS - 1) * COLS - 1);
  localparam logic [5:0]        COL_MAX   = 6'(COLS - 1);
  localparam logic [4:0]        ROW_MAX   = 5'(ROWS - 1);

  state_t            state_q, state_d;
  logic [5:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        char_q, char_d;
  logic [ADDR_W-1:0] cursor_addr;
  logic              unused_data;

  assign unused_data = ^bus.cmd_data[15:13];
  assign cursor_addr = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      char_q  <= char_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    char_d  = char_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'b00: begin
              if (bus.cmd_data[7:0] == 8'h0D) begin
                col_d = '0;
              end else if (bus.cmd_data[7:0] == 8'h0A) begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                  state_d = SCR_RD;
                  addr_d  = '0;
                end else begin
                  row_d = row_q + 5'd1;
                end
              end else begin
                state_d = PUT;
                addr_d  = cursor_addr;
                char_d  = bus.cmd_data[7:0];
              end
            end
            2'b01: begin
              col_d = (bus.cmd_data[5:0]  > COL_MAX) ? COL_MAX : bus.cmd_data[5:0];
              row_d = (bus.cmd_data[12:8] > ROW_MAX) ? ROW_MAX : bus.cmd_data[12:8];
            end
            2'b10: begin
              state_d = CLEAR;
              addr_d  = '0;
            end
            default: begin
              state_d = SCR_RD;
              addr_d  = '0;
            end
          endcase
        end
      end
      PUT: begin
        state_d = IDLE;
        if (col_q == COL_MAX) begin
          col_d = '0;
          // Wrapping off the bottom row starts an automatic scroll; cursor stays on last row.
          if (row_q == ROW_MAX) begin
            state_d = SCR_RD;
            addr_d  = '0;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      CLEAR: begin
        if (addr_q == LAST_A) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      SCR_RD: state_d = SCR_WR;
      SCR_WR: begin
        // The step past the last moved cell lands exactly on the first fill address.
        addr_d  = addr_q + 1'b1;
        state_d = (addr_q == MV_LAST_A) ? SCR_FILL : SCR_RD;
      end
      SCR_FILL: begin
        if (addr_q == LAST_A) state_d = IDLE;
        else                  addr_d  = addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    case (state_q)
      PUT: begin
        bus.ram_addr  = addr_q;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = char_q;
      end
      CLEAR, SCR_FILL: begin
        bus.ram_addr  = addr_q;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = CLR_CHAR;
      end
      SCR_RD: bus.ram_addr = addr_q + COLS_A;
      SCR_WR: begin
        bus.ram_addr  = addr_q;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = bus.ram_rdata;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q == CLEAR) || (state_q == SCR_RD) ||
                         (state_q == SCR_WR) || (state_q == SCR_FILL);
  assign cur_col       = col_q;
  assign cur_row       = row_q;

endmodule
